// File: rtl/traffic_conflict_monitor_if.sv
// Signal bundle between a signal controller (master) and the conflict monitor (slave).
// The controller drives lamp and pedestrian states plus the operator clear request.
// The monitor returns its fault status and the all-flash request.
interface traffic_conflict_monitor_if;
    logic [2:0] light_NS;
    logic [2:0] light_EW;
    logic       ped_signal_NS;
    logic       ped_signal_EW;
    logic       fault_clear;
    logic       fault;
    logic [2:0] fault_code;
    logic       flash_req;
    logic [7:0] fault_count;
    logic       armed;

    modport master (
        output light_NS, light_EW, ped_signal_NS, ped_signal_EW, fault_clear,
        input  fault, fault_code, flash_req, fault_count, armed
    );

    modport slave (
        input  light_NS, light_EW, ped_signal_NS, ped_signal_EW, fault_clear,
        output fault, fault_code, flash_req, fault_count, armed
    );
endinterface

// File: rtl/traffic_conflict_monitor.sv
// Traffic lamp conflict monitor.
// Lamp encoding per direction: bit2 red, bit1 yellow, bit0 green.
// Waits in ARMING for an all-red sample, then watches for static conditions
// (conflicting greens, malformed lamp codes, walk against a non-red lamp) that
// must persist PERSIST samples, and sequence violations (green straight to red,
// short yellow, green held too long) that trip immediately. The first qualifying
// condition latches a fault and requests all-flash until the operator clears it.
module traffic_conflict_monitor #(
    parameter int MIN_YELLOW = 3,
    parameter int MAX_GREEN  = 1000,
    parameter int PERSIST    = 2
) (
    input logic                     clk,
    input logic                     rst,
    traffic_conflict_monitor_if.slave bus
);

    localparam logic [1:0] ARMING  = 2'd0;
    localparam logic [1:0] MONITOR = 2'd1;
    localparam logic [1:0] FAULT   = 2'd2;

    localparam int YW = (MIN_YELLOW < 1) ? 1 : $clog2(MIN_YELLOW + 1);
    localparam int GW = (MAX_GREEN < 2) ? 1 : $clog2(MAX_GREEN + 1);

    localparam logic [3:0]    PER_MAX  = 4'(PERSIST);
    localparam logic [3:0]    PER_LAST = 4'(PERSIST - 1);
    localparam logic [YW-1:0] YEL_MAX  = YW'(MIN_YELLOW);
    localparam logic [GW-1:0] GRN_MAX  = GW'(MAX_GREEN);
    localparam logic [GW-1:0] GRN_LAST = GW'(MAX_GREEN - 1);

    logic [1:0]    state, state_next;
    logic [2:0]    prev_ns, prev_ew;
    logic [3:0]    per_conf, per_inv, per_ped;
    logic [3:0]    per_conf_next, per_inv_next, per_ped_next;
    logic [YW-1:0] yel_ns, yel_ew, yel_ns_next, yel_ew_next;
    logic [GW-1:0] grn_ns, grn_ew, grn_ns_next, grn_ew_next;
    logic          fault_q, armed_q;
    logic [2:0]    code_q, code_next;
    logic [7:0]    count_q, count_next;

    logic [2:0] ns, ew;
    logic       mon;
    logic       conf_now, inv_now, ped_now, static_now;
    logic       q1, q2, q3, q4, q5, q6, any_q;
    logic [2:0] lowest_code;

    // Persistence counter: counts consecutive samples with the condition, saturating.
    function automatic logic [3:0] per_step(input logic [3:0] cnt, input logic present);
        if (!present)
            return 4'd0;
        return (cnt >= PER_MAX) ? cnt : cnt + 4'd1;
    endfunction

    function automatic logic [YW-1:0] yel_step(input logic [YW-1:0] cnt, input logic yellow);
        if (!yellow)
            return '0;
        return (cnt >= YEL_MAX) ? cnt : cnt + YW'(1);
    endfunction

    function automatic logic [GW-1:0] grn_step(input logic [GW-1:0] cnt, input logic green);
        if (!green)
            return '0;
        return (cnt >= GRN_MAX) ? cnt : cnt + GW'(1);
    endfunction

    function automatic logic [7:0] count_sat_inc(input logic [7:0] cnt);
        return (cnt == 8'hFF) ? cnt : cnt + 8'd1;
    endfunction

    assign ns  = bus.light_NS;
    assign ew  = bus.light_EW;
    assign mon = (state == MONITOR);

    // Raw condition detection on the current sample and qualification against history.
    always_comb begin
        conf_now   = (ns[0] && !ew[2]) || (ew[0] && !ns[2]);
        inv_now    = !$onehot0(ns) || !$onehot0(ew);
        ped_now    = (bus.ped_signal_NS && !ns[2]) || (bus.ped_signal_EW && !ew[2]);
        static_now = conf_now || inv_now || ped_now;

        q1 = mon && conf_now && (per_conf >= PER_LAST);
        q2 = mon && inv_now  && (per_inv  >= PER_LAST);
        q3 = mon && ped_now  && (per_ped  >= PER_LAST);
        q4 = mon && ((prev_ns[0] && ns[2]) || (prev_ew[0] && ew[2]));
        q5 = mon && ((prev_ns[1] && ns[2] && (yel_ns < YEL_MAX)) ||
                     (prev_ew[1] && ew[2] && (yel_ew < YEL_MAX)));
        q6 = mon && ((ns[0] && (grn_ns >= GRN_LAST)) || (ew[0] && (grn_ew >= GRN_LAST)));
        any_q = q1 || q2 || q3 || q4 || q5 || q6;

        lowest_code = 3'd0;
        if      (q1) lowest_code = 3'd1;
        else if (q2) lowest_code = 3'd2;
        else if (q3) lowest_code = 3'd3;
        else if (q4) lowest_code = 3'd4;
        else if (q5) lowest_code = 3'd5;
        else if (q6) lowest_code = 3'd6;
    end

    // Counters run only while monitoring; elsewhere they sit at zero.
    always_comb begin
        per_conf_next = mon ? per_step(per_conf, conf_now) : 4'd0;
        per_inv_next  = mon ? per_step(per_inv, inv_now)   : 4'd0;
        per_ped_next  = mon ? per_step(per_ped, ped_now)   : 4'd0;
        yel_ns_next   = mon ? yel_step(yel_ns, ns[1])      : '0;
        yel_ew_next   = mon ? yel_step(yel_ew, ew[1])      : '0;
        grn_ns_next   = mon ? grn_step(grn_ns, ns[0])      : '0;
        grn_ew_next   = mon ? grn_step(grn_ew, ew[0])      : '0;
    end

    // State transitions, fault code capture and fault counting.
    always_comb begin
        state_next = state;
        code_next  = code_q;
        count_next = count_q;
        case (state)
            ARMING: begin
                if (ns == 3'b100 && ew == 3'b100)
                    state_next = MONITOR;
            end
            MONITOR: begin
                if (any_q) begin
                    state_next = FAULT;
                    code_next  = lowest_code;
                    count_next = count_sat_inc(count_q);
                end
            end
            FAULT: begin
                // A clear is refused while any static condition is still visible.
                if (bus.fault_clear && !static_now) begin
                    state_next = ARMING;
                    code_next  = 3'd0;
                end
            end
            default: begin
                state_next = ARMING;
                code_next  = 3'd0;
            end
        endcase
    end

    // Register all state, history, counters and outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= ARMING;
            prev_ns  <= 3'd0;
            prev_ew  <= 3'd0;
            per_conf <= 4'd0;
            per_inv  <= 4'd0;
            per_ped  <= 4'd0;
            yel_ns   <= '0;
            yel_ew   <= '0;
            grn_ns   <= '0;
            grn_ew   <= '0;
            fault_q  <= 1'b0;
            armed_q  <= 1'b0;
            code_q   <= 3'd0;
            count_q  <= 8'd0;
        end else begin
            state    <= state_next;
            prev_ns  <= ns;
            prev_ew  <= ew;
            per_conf <= per_conf_next;
            per_inv  <= per_inv_next;
            per_ped  <= per_ped_next;
            yel_ns   <= yel_ns_next;
            yel_ew   <= yel_ew_next;
            grn_ns   <= grn_ns_next;
            grn_ew   <= grn_ew_next;
            fault_q  <= (state_next == FAULT);
            armed_q  <= (state_next == MONITOR);
            code_q   <= code_next;
            count_q  <= count_next;
        end
    end

    assign bus.fault       = fault_q;
    assign bus.flash_req   = fault_q;
    assign bus.fault_code  = code_q;
    assign bus.fault_count = count_q;
    assign bus.armed       = armed_q;

endmodule

// File: tb/tb_traffic_conflict_monitor.sv
// Directed bench for the traffic conflict monitor with default parameters
// (MIN_YELLOW=3, MAX_GREEN=1000, PERSIST=2).
module tb_traffic_conflict_monitor;

    localparam logic [2:0] R = 3'b100;
    localparam logic [2:0] Y = 3'b010;
    localparam logic [2:0] G = 3'b001;
    localparam logic [2:0] O = 3'b000;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    traffic_conflict_monitor_if bus ();

    traffic_conflict_monitor #(
        .MIN_YELLOW(3),
        .MAX_GREEN (1000),
        .PERSIST   (2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic [2:0] ns;
        logic [2:0] ew;
        logic       pn;
        logic       pe;
        logic       clr;
        logic       f;
        logic [2:0] code;
        logic [7:0] cnt;
        logic       armed;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input string n, input logic [2:0] ns, input logic [2:0] ew,
                       input logic pn, input logic pe, input logic clr,
                       input logic f, input logic [2:0] code, input logic [7:0] cnt,
                       input logic armed);
        vec_t v;
        v.name = n; v.ns = ns; v.ew = ew; v.pn = pn; v.pe = pe; v.clr = clr;
        v.f = f; v.code = code; v.cnt = cnt; v.armed = armed;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_outs(input string name, input logic f, input logic [2:0] code,
                              input logic [7:0] cnt, input logic armed);
        check($sformatf("%s/fault", name), 32'(bus.fault), 32'(f));
        check($sformatf("%s/flash_req", name), 32'(bus.flash_req), 32'(f));
        check($sformatf("%s/fault_code", name), 32'(bus.fault_code), 32'(code));
        check($sformatf("%s/fault_count", name), 32'(bus.fault_count), 32'(cnt));
        check($sformatf("%s/armed", name), 32'(bus.armed), 32'(armed));
    endtask

    // Apply one sample, clock it in, and leave time 1 unit after the edge.
    task automatic step(input logic [2:0] ns, input logic [2:0] ew,
                        input logic pn, input logic pe, input logic clr);
        bus.light_NS      = ns;
        bus.light_EW      = ew;
        bus.ped_signal_NS = pn;
        bus.ped_signal_EW = pe;
        bus.fault_clear   = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        step(O, O, 0, 0, 0);
        step(O, O, 0, 0, 0);
        rst = 1'b1;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst = 1'b0;
        bus.light_NS = O; bus.light_EW = O;
        bus.ped_signal_NS = 0; bus.ped_signal_EW = 0; bus.fault_clear = 0;

        //    name             NS    EW      pn pe clr  f code cnt armed
        add("prearm_green",    G,    R,      0, 0, 0,   0, 0, 0, 0);
        add("prearm_conf",     G,    G,      0, 0, 0,   0, 0, 0, 0);
        add("arm",             R,    R,      0, 0, 0,   0, 0, 0, 1);
        add("conf_glitch",     G,    O,      0, 0, 0,   0, 0, 0, 1);
        add("conf_gone",       G,    R,      0, 0, 0,   0, 0, 0, 1);
        add("yel_a1",          Y,    R,      0, 0, 0,   0, 0, 0, 1);
        add("yel_a2",          Y,    R,      0, 0, 0,   0, 0, 0, 1);
        add("yel_a3",          Y,    R,      0, 0, 0,   0, 0, 0, 1);
        add("yel3_red",        R,    R,      0, 0, 0,   0, 0, 0, 1);
        add("yel_b1",          Y,    R,      0, 0, 0,   0, 0, 0, 1);
        add("yel_b2",          Y,    R,      0, 0, 0,   0, 0, 0, 1);
        add("yel2_red",        R,    R,      0, 0, 0,   1, 5, 1, 0);
        add("clear1",          R,    R,      0, 0, 1,   0, 0, 1, 0);
        add("rearm1",          R,    R,      0, 0, 0,   0, 0, 1, 1);
        add("green",           G,    R,      0, 0, 0,   0, 0, 1, 1);
        add("green_red",       R,    R,      0, 0, 0,   1, 4, 2, 0);
        add("clear2",          R,    R,      0, 0, 1,   0, 0, 2, 0);
        add("rearm2",          R,    R,      0, 0, 0,   0, 0, 2, 1);
        add("conf1",           G,    G,      0, 0, 0,   0, 0, 2, 1);
        add("conf2",           G,    G,      0, 0, 0,   1, 1, 3, 0);
        add("clr_blocked",     G,    G,      0, 0, 1,   1, 1, 3, 0);
        add("fault_hold",      G,    G,      0, 0, 0,   1, 1, 3, 0);
        add("clear3",          R,    R,      0, 0, 1,   0, 0, 3, 0);
        add("rearm3",          R,    R,      0, 0, 0,   0, 0, 3, 1);
        add("inv_ped1",        G,    3'b110, 1, 0, 0,   0, 0, 3, 1);
        add("inv_ped2",        G,    3'b110, 1, 0, 0,   1, 2, 4, 0);
        add("clr_blocked2",    G,    3'b110, 1, 0, 1,   1, 2, 4, 0);
        add("clear4",          R,    R,      0, 0, 1,   0, 0, 4, 0);
        add("rearm4",          R,    R,      0, 0, 0,   0, 0, 4, 1);
        add("clr_idle",        R,    R,      0, 0, 1,   0, 0, 4, 1);
        add("ped1",            G,    R,      1, 0, 0,   0, 0, 4, 1);
        add("ped2",            G,    R,      1, 0, 0,   1, 3, 5, 0);

        // Reset state
        do_reset();
        check_outs("reset", 0, 0, 0, 0);

        // Table-driven sequence, one row per clock edge
        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].ns, vecs[i].ew, vecs[i].pn, vecs[i].pe, vecs[i].clr);
            check_outs(vecs[i].name, vecs[i].f, vecs[i].code, vecs[i].cnt, vecs[i].armed);
        end

        // Asynchronous reset while in FAULT discards the fault and the count
        #2;
        rst = 1'b0;
        #1;
        check_outs("async_rst", 0, 0, 0, 0);
        step(R, R, 0, 0, 0);
        check_outs("rst_held", 0, 0, 0, 0);
        rst = 1'b1;

        // Green watchdog: trips on the 1000th consecutive green sample
        step(R, R, 0, 0, 0);
        check_outs("wd_arm", 0, 0, 0, 1);
        for (int i = 0; i < 999; i++)
            step(G, R, 0, 0, 0);
        check_outs("wd_999", 0, 0, 0, 1);
        step(G, R, 0, 0, 0);
        check_outs("wd_1000", 1, 6, 1, 0);

        // Night flash: both directions alternating yellow / dark never faults
        step(R, R, 0, 0, 1);
        check_outs("wd_clear", 0, 0, 1, 0);
        step(R, R, 0, 0, 0);
        for (int i = 0; i < 2000; i++) begin
            if (i % 2 == 0) step(Y, Y, 0, 0, 0);
            else            step(O, O, 0, 0, 0);
        end
        check_outs("night_flash", 0, 0, 1, 1);

        // Fault counter saturates at 255
        do_reset();
        for (int i = 0; i < 257; i++) begin
            step(R, R, 0, 0, 0);
            step(G, R, 0, 0, 0);
            step(R, R, 0, 0, 0);
            if (i == 0)
                check_outs("sat_first", 1, 4, 1, 0);
            if (i == 254)
                check_outs("sat_255", 1, 4, 255, 0);
            if (i < 256)
                step(R, R, 0, 0, 1);
        end
        check_outs("sat_hold", 1, 4, 255, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/traffic_conflict_monitor.md
TRAFFIC_CONFLICT_MONITOR -- requirements
Module: traffic_conflict_monitor

Interface
REQ-001 SHALL have parameter MIN_YELLOW, default 3, minimum consecutive yellow samples before yellow->red.
REQ-002 SHALL have parameter MAX_GREEN, default 1000, consecutive green samples that trip the watchdog.
REQ-003 SHALL have parameter PERSIST, default 2 (legal 1..15), consecutive samples a static condition must hold before latching.
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 rst  input  1  asynchronous, active-low reset.
REQ-006 light_NS  input  3  NS lamp state: bit2 red, bit1 yellow, bit0 green.
REQ-007 light_EW  input  3  EW lamp state, same encoding.
REQ-008 ped_signal_NS  input  1  NS walk indication.
REQ-009 ped_signal_EW  input  1  EW walk indication.
REQ-010 fault_clear  input  1  single-cycle operator clear request.
REQ-011 fault  output  1  latched fault flag.
REQ-012 fault_code  output  3  cause of latched fault; 0 = none.
REQ-013 flash_req  output  1  request to controller to enter all-flash; equals fault.
REQ-014 fault_count  output  8  number of fault entries, saturating.
REQ-015 armed  output  1  high while in MONITOR state.

Function
REQ-016 Inputs SHALL be sampled every rising edge; all outputs SHALL be registered.
REQ-017 FSM states SHALL be ARMING, MONITOR, FAULT.
REQ-018 ARMING: no checks; all internal counters held at 0; on a sample with light_NS=3'b100 and light_EW=3'b100, next state MONITOR.
REQ-019 Static conditions (evaluated in MONITOR): code 1 conflict = (NS green and EW not red) or (EW green and NS not red); code 2 invalid = either light neither one-hot nor 3'b000; code 3 ped = ped_signal_X high while light_X not red.
REQ-020 Each static condition SHALL have its own persistence counter: increments per sample while present, clears when absent; condition qualifies when counter reaches PERSIST.
REQ-021 Sequence conditions (MONITOR, qualify immediately, per direction): code 4 = previous sample green, current red; code 5 = previous yellow, current red, consecutive-yellow count < MIN_YELLOW; code 6 = consecutive-green count reaches MAX_GREEN.
REQ-022 Yellow->3'b000 and 3'b000->yellow (night flash) SHALL NOT be faults; both directions flashing yellow SHALL NOT be conflict.
REQ-023 On any qualifying condition: next state FAULT, fault=1, flash_req=1, fault_code = lowest qualifying code number, fault_count += 1 saturating at 255.
REQ-024 In FAULT: fault_code frozen; new conditions SHALL NOT change code or count.
REQ-025 fault_clear in FAULT SHALL be accepted only if no static condition is present in that same sample; accepted -> ARMING, fault=0, fault_code=0 next edge; otherwise ignored.
REQ-026 fault_clear outside FAULT SHALL be ignored.
REQ-027 Previous-light registers SHALL update every sample in all states; yellow/green counters saturate at their thresholds.
REQ-028 armed SHALL be 1 exactly when state is MONITOR.

Reset
REQ-029 rst low SHALL immediately force ARMING, fault=0, flash_req=0, fault_code=0, fault_count=0, armed=0, all counters and previous-light registers to 0, regardless of clock.
REQ-030 rst low mid-FAULT SHALL discard the fault; fault_count SHALL return to 0.

Verification
REQ-031 Reset release, both lights 3'b100 one edge -> armed=1 next edge; prior non-red samples never raise fault.
REQ-032 Armed, NS=3'b001, EW=3'b001 for 2 edges (PERSIST=2) -> fault=1, fault_code=1, fault_count=1; single-edge glitch -> no fault.
REQ-033 Armed, NS yellow 2 edges then red (MIN_YELLOW=3) -> fault_code=5; yellow 3 edges then red -> no fault; green directly to red -> fault_code=4.
REQ-034 Armed, ped_signal_NS=1 with NS green and light_EW=3'b110 same samples -> fault_code=2 (priority over 3).
REQ-035 In FAULT, fault_clear with conflict still present -> stays FAULT; fault_clear after conflict removed -> fault=0, armed=0, then all-red sample re-arms.
REQ-036 NS green for 1000 consecutive armed samples (MAX_GREEN=1000) -> fault_code=6 on the 1000th; both lights flashing yellow/000 for 2000 cycles -> no fault.
